// File: rtl/hwpe_stream_sink_sched_pkg.sv
// hwpe_stream_sink_sched_pkg
// Purpose: shared types for the sink job sequencer. The package holds the job
// record that sits in the job queue and is latched for the sink. It also holds
// the sequencer state encoding.
// Ports: none (package only).
package hwpe_stream_sink_sched_pkg;

  // Word-count width stored in the queue; the top converts its ports to and from it.
  localparam int unsigned SINK_SCHED_TRANS_CNT = 16;

  typedef struct packed {
    logic [31:0]                     addr;
    logic [SINK_SCHED_TRANS_CNT-1:0] words;
    logic [31:0]                     stride;
  } sink_sched_job_t;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_WAIT_DONE
  } state_sink_sched_t;

endpackage

// File: rtl/hwpe_stream_sink_sched_fifo.sv
// hwpe_stream_sink_sched_fifo
// Purpose: synchronous queue of sink jobs. Push and pop may happen in the same
// cycle. The queue has a synchronous flush and a first-word-visible head.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        drop all entries (same effect as reset on the queue)
//   push_i/data_i  enqueue request and job (ignored when full)
//   pop_i          dequeue request (ignored when empty)
//   head_o         oldest job, valid while empty_o is low
//   full_o/empty_o occupancy flags, count_o current number of entries
module hwpe_stream_sink_sched_fifo
  import hwpe_stream_sink_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  sink_sched_job_t        data_i,
  input  logic                   pop_i,
  output sink_sched_job_t        head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  sink_sched_job_t mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q;
  logic [AW-1:0]   rdPtr_q;
  logic [CW-1:0]   count_q;
  logic            doPush;
  logic            doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Pointers and occupancy; flush behaves exactly like reset for the queue.
  // DEPTH is a power of two, so the pointers wrap for free.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/hwpe_stream_sink_sched.sv
// hwpe_stream_sink_sched
// Purpose: job sequencer for one hwpe_stream_sink. Jobs from the control plane
// are queued. Each non-empty job is started on the sink with a req/ready
// handshake, and the sequencer then waits for the sink's done pulse.
// Completions are counted. Zero-length jobs complete without touching the sink.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   abort_i             flush queue, pulse sink_clear_o, return to idle
//   job_*               job push interface (valid/ready, addr, words, stride)
//   sink_ready_start_i  sink can accept a start
//   sink_done_i         sink finished the running job (1-cycle pulse)
//   sink_req_start_o    start request to the sink
//   sink_base_addr_o, sink_trans_size_o, sink_stride_o  job fields for the sink
//   sink_clear_o        1-cycle clear to the sink after an abort
//   busy_o              sequencer active or jobs pending
//   evt_done_o          1-cycle pulse per completed job
//   jobs_done_o         wrapping count of completed jobs
module hwpe_stream_sink_sched
  import hwpe_stream_sink_sched_pkg::*;
#(
  parameter int unsigned JOB_FIFO_DEPTH = 4,
  parameter int unsigned TRANS_CNT      = 16,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 abort_i,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [31:0]          job_addr_i,
  input  logic [TRANS_CNT-1:0] job_words_i,
  input  logic [31:0]          job_stride_i,
  input  logic                 sink_ready_start_i,
  input  logic                 sink_done_i,
  output logic                 sink_req_start_o,
  output logic [31:0]          sink_base_addr_o,
  output logic [TRANS_CNT-1:0] sink_trans_size_o,
  output logic [31:0]          sink_stride_o,
  output logic                 sink_clear_o,
  output logic                 busy_o,
  output logic                 evt_done_o,
  output logic [CNT_WIDTH-1:0] jobs_done_o
);

  localparam int unsigned QCW = $clog2(JOB_FIFO_DEPTH) + 1;

  state_sink_sched_t    state_q;
  sink_sched_job_t      latched_q;
  logic [CNT_WIDTH-1:0] jobsDone_q;
  logic                 evtDone_q;
  logic                 clear_q;

  sink_sched_job_t newJob;
  sink_sched_job_t headJob;
  sink_sched_job_t ctrlJob;
  logic            fifoFull;
  logic            fifoEmpty;
  logic [QCW-1:0]  fifoCount;
  logic [QCW-1:0]  nextCount;
  logic            push;
  logic            pop;
  logic            headZero;
  logic            issueActive;
  logic            nextNonEmpty;

  assign newJob = '{addr:   job_addr_i,
                    words:  SINK_SCHED_TRANS_CNT'(job_words_i),
                    stride: job_stride_i};

  // Abort drops a same-cycle push and blocks any pop, so the flushed queue stays empty.
  assign job_ready_o  = !fifoFull;
  assign push         = job_valid_i && !fifoFull && !abort_i;
  assign issueActive  = (state_q == SCHED_ISSUE) && !fifoEmpty && !abort_i;
  assign headZero     = (headJob.words == '0);
  assign pop          = issueActive && (headZero || sink_ready_start_i);
  // Queue occupancy after this edge, used to pick ISSUE or IDLE after a completion.
  assign nextCount    = fifoCount + QCW'(push) - QCW'(pop);
  assign nextNonEmpty = (nextCount != '0);

  hwpe_stream_sink_sched_fifo #(
    .DEPTH (JOB_FIFO_DEPTH)
  ) i_job_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (abort_i),
    .push_i  (push),
    .data_i  (newJob),
    .pop_i   (pop),
    .head_o  (headJob),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // The sink sees the queue head while a start is pending and the latched copy otherwise.
  assign ctrlJob           = (state_q == SCHED_ISSUE) ? headJob : latched_q;
  assign sink_req_start_o  = issueActive && !headZero;
  assign sink_base_addr_o  = ctrlJob.addr;
  assign sink_trans_size_o = TRANS_CNT'(ctrlJob.words);
  assign sink_stride_o     = ctrlJob.stride;
  assign sink_clear_o      = clear_q;
  assign busy_o            = (state_q != SCHED_IDLE) || !fifoEmpty;
  assign evt_done_o        = evtDone_q;
  assign jobs_done_o       = jobsDone_q;

  // Sequencer FSM with its registered outputs, latched job copy and completion counter.
  // Abort wins over every state transition, and a done pulse in the abort cycle is not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SCHED_IDLE;
      latched_q  <= '0;
      jobsDone_q <= '0;
      evtDone_q  <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      evtDone_q <= 1'b0;
      clear_q   <= abort_i;
      if (abort_i) begin
        state_q <= SCHED_IDLE;
      end else begin
        case (state_q)
          SCHED_IDLE: begin
            if (!fifoEmpty) state_q <= SCHED_ISSUE;
          end
          SCHED_ISSUE: begin
            if (pop && headZero) begin
              evtDone_q  <= 1'b1;
              jobsDone_q <= jobsDone_q + CNT_WIDTH'(1);
              state_q    <= nextNonEmpty ? SCHED_ISSUE : SCHED_IDLE;
            end else if (pop) begin
              latched_q <= headJob;
              state_q   <= SCHED_WAIT_DONE;
            end else if (fifoEmpty) begin
              state_q <= SCHED_IDLE;
            end
          end
          SCHED_WAIT_DONE: begin
            if (sink_done_i) begin
              evtDone_q  <= 1'b1;
              jobsDone_q <= jobsDone_q + CNT_WIDTH'(1);
              state_q    <= nextNonEmpty ? SCHED_ISSUE : SCHED_IDLE;
            end
          end
          default: state_q <= SCHED_IDLE;
        endcase
      end
    end
  end

endmodule
